button_event_sched: RTL
=======================

Name: button_event_sched

Overview:
- Debounces NUM_BTN raw push-buttons through one shared tick prescaler and per-button saturating counters.
- Queues a press event per button and hands events one at a time to the CPU input port over a valid/ack handshake.
- Round-robin arbitration prevents a chattering or held-busy button from starving the others.
- Sits between board button pins and the processor I/O input path; replaces per-button free-running debouncers.

Parameters:
- NUM_BTN, 4, number of buttons; legal range 2..16.
- PRESCALE, 1024, clk cycles per sample tick; must be ≥2.
- DB_TICKS, 8, consecutive disagreeing ticks required to flip a stable state; must be ≥2.
- ID_W, derived as clog2(NUM_BTN); local, not overridable.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_in  in  NUM_BTN  raw button levels, asynchronous; 1 = pressed.
- evt_ack  in  1  consumer accepts the current event; sampled only while evt_valid=1.
- ovf_clr  in  1  clears ovf.
- btn_state  out  NUM_BTN  debounced stable levels.
- evt_valid  out  1  event presented.
- evt_id  out  ID_W  index of the button that produced the event.
- ovf  out  1  sticky flag: a press was lost.

Behaviour:
- Reset values: btn_state=0, evt_valid=0, evt_id=0, ovf=0, all pend=0, rr_ptr=0, prescaler=0, debounce counters=0, synchronizers=0.
- Synchronizer: each btn_in bit passes through a 2-FF synchronizer giving sync[i].
- Prescaler: counts 0..PRESCALE-1 and wraps. tick is a one-cycle pulse when the count equals PRESCALE-1.
- Debounce, per button:
  - Any cycle with sync[i]==btn_state[i] clears cnt[i].
  - On a tick with sync[i]!=btn_state[i]: if cnt[i]==DB_TICKS-1, then btn_state[i]<=sync[i] and cnt[i]<=0; otherwise cnt[i] increments.
  - A flip therefore needs DB_TICKS consecutive disagreeing ticks. A glitch shorter than one tick period never flips the state.
- Press detect: a btn_state[i] 0→1 transition sets pend[i] in the same clock edge that updates btn_state[i].
- Arbiter FSM, states IDLE and PRESENT:
  - IDLE: if any pend bit is set, search from rr_ptr upward with wrap. Load evt_id with the first set index, set evt_valid=1, go to PRESENT.
  - PRESENT: evt_id and evt_valid hold steady until evt_ack=1.
  - On ack: clear pend[evt_id], set evt_valid<=0, set rr_ptr<=evt_id+1 (wrapping NUM_BTN-1→0), return to IDLE.
  - There is a mandatory one-cycle bubble between consecutive events.
- Pend bits set while in PRESENT wait for the next IDLE scan. They do not change evt_id.
- Overflow: a press on button i while pend[i]=1 and pend[i] is not being cleared that cycle sets ovf; pend[i] stays 1 and no event is duplicated.
- Press on i in the same cycle as an ack of i: pend[i] stays 1 (the new press is kept) and ovf is unchanged.
- ovf_clr: clears ovf. If ovf_clr and a new overflow occur in the same cycle, set wins.
- Releases: a btn_state 1→0 transition updates btn_state only and produces no event (unless the optional feature is enabled).
- Reset mid-operation: asynchronous return to the reset values. Pending and presented events are discarded.

Optional Feature:
- Macro: BTN_RELEASE_EVT_EN.
- When defined:
  - Adds output evt_release (1 bit) and a second pending vector pend_rel, set on each btn_state 1→0 transition.
  - Arbitration runs over 2*NUM_BTN slots: slot 2i = press of i, slot 2i+1 = release of i. rr_ptr widens to cover all slots.
  - evt_release=1 for release slots. Overflow rules apply per slot.
- When undefined: the evt_release port is absent, no pend_rel logic exists, and releases are silent.

Test Plan (PRESCALE=4, DB_TICKS=3, NUM_BTN=4 unless stated):
- Assert reset mid-count, then release → all outputs 0; with btn_in=4'b0000, evt_valid stays 0 for 100 cycles.
- btn_in[2] 0→1 and held → btn_state[2]=1 between cycles 11 and 15 after the edge; evt_valid=1 with evt_id=2 one cycle later; evt_ack pulse → evt_valid=0 next cycle.
- btn_in[1] pulses high for 3 cycles only → btn_state stays 0 and no event.
- Buttons 0 and 3 pressed simultaneously, rr_ptr=0 → events are id 0 then id 3. Next simultaneous 0+3 press with rr_ptr=1 → id 3 first, then 0.
- Press button 1, release, press again with no ack → ovf=1 and exactly one event with id 1. ovf_clr → ovf=0.
- With BTN_RELEASE_EVT_EN: press then release button 0 with ack after each → events (id 0, evt_release=0) then (id 0, evt_release=1).

Source files
------------

// File: rtl/button_event_sched.sv
// ---------------------------------------------------------------------------
// button_event_sched
//
// Debounces NUM_BTN raw push-buttons and delivers their press events to the
// CPU input port one at a time over a valid/ack handshake.
//
// - A 2-FF synchronizer on every button input.
// - One shared prescaler that produces the debounce sample tick.
// - A saturating counter per button. DB_TICKS consecutive disagreeing ticks
//   flip the debounced level.
// - A pending bit per event slot.
// - A round-robin arbiter that picks the next slot after the last one served,
//   so a chattering button cannot starve the others.
//
// Optional build feature (macro BTN_RELEASE_EVT_EN):
//   Release transitions also raise events. Slot 2i is the press of button i
//   and slot 2i+1 is its release. The evt_release port marks release events.
//   When the macro is undefined, releases are silent and the port is absent.
//
// Parameters:
//   NUM_BTN   number of buttons (2..16)
//   PRESCALE  clk cycles per debounce sample tick (>= 2)
//   DB_TICKS  consecutive disagreeing ticks needed to flip a level (>= 2)
//   ID_W      width of evt_id, derived from NUM_BTN
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   btn_in       raw button levels, asynchronous, 1 = pressed
//   evt_ack      consumer accepts the presented event (sampled while evt_valid)
//   ovf_clr      clears the sticky overflow flag
//   btn_state    debounced stable levels
//   evt_valid    an event is presented
//   evt_id       button index of the presented event
//   evt_release  presented event is a release (only with BTN_RELEASE_EVT_EN)
//   ovf          sticky: a press arrived while its slot was still pending
// ---------------------------------------------------------------------------
module button_event_sched #(
    parameter int NUM_BTN  = 4,
    parameter int PRESCALE = 1024,
    parameter int DB_TICKS = 8,
    localparam int ID_W    = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic               evt_ack,
    input  logic               ovf_clr,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
`ifdef BTN_RELEASE_EVT_EN
    output logic               evt_release,
`endif
    output logic               ovf
);

    localparam int PW = $clog2(PRESCALE);
    localparam int CW = $clog2(DB_TICKS);
`ifdef BTN_RELEASE_EVT_EN
    localparam int NSLOT = 2 * NUM_BTN;
`else
    localparam int NSLOT = NUM_BTN;
`endif
    localparam int SW = $clog2(NSLOT);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_e;

    // Synchronizer
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    // Prescaler
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    // Debounce
    logic [CW-1:0]      cnt_q [NUM_BTN];
    logic [CW-1:0]      cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] btn_state_q;
    logic [NUM_BTN-1:0] btn_state_d;
    logic [NUM_BTN-1:0] rise;

    // Event slots
    logic [NSLOT-1:0] pend_q;
    logic [NSLOT-1:0] pend_d;
    logic [NSLOT-1:0] slot_set;
    logic [NSLOT-1:0] slot_clr;
    logic             ovf_q;
    logic             ovf_d;
    logic             ovf_set;

    // Arbiter
    arb_state_e state_q;
    arb_state_e state_d;
    logic [SW-1:0] cur_slot_q;
    logic [SW-1:0] cur_slot_d;
    logic [SW-1:0] rr_ptr_q;
    logic [SW-1:0] rr_ptr_d;
    logic [SW-1:0] scan_idx;
    logic [SW-1:0] pick;
    logic          found;
    logic          ack;

    // -----------------------------------------------------------------------
    // Prescaler: counts 0..PRESCALE-1 and pulses tick on the last count.
    // -----------------------------------------------------------------------
    always_comb begin
        tick    = (presc_q == PW'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // -----------------------------------------------------------------------
    // Debounce. Any cycle where the synchronized level matches the stable
    // level restarts the count, so only consecutive disagreeing ticks add up.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch. A path that leaves a signal unassigned infers a latch.
        btn_state_d = btn_state_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == btn_state_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CW'(DB_TICKS - 1)) begin
                    btn_state_d[i] = sync2_q[i];
                    cnt_d[i]       = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        rise = btn_state_d & ~btn_state_q;
    end

    // Map debounced transitions onto event slots.
`ifdef BTN_RELEASE_EVT_EN
    logic [NUM_BTN-1:0] fall;

    always_comb begin
        fall     = btn_state_q & ~btn_state_d;
        slot_set = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            slot_set[2*i]     = rise[i];
            slot_set[2*i + 1] = fall[i];
        end
    end
`else
    always_comb begin
        slot_set = rise;
    end
`endif

    // -----------------------------------------------------------------------
    // Round-robin search: the first pending slot at or after rr_ptr, with wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int k = 0; k < NSLOT; k++) begin
            scan_idx = SW'((int'(rr_ptr_q) + k) % NSLOT);
            if (!found && pend_q[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Arbiter FSM: next state and handshake.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cur_slot_d = cur_slot_q;
        rr_ptr_d   = rr_ptr_q;
        ack        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    cur_slot_d = pick;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ack) begin
                    ack      = 1'b1;
                    state_d  = IDLE;
                    rr_ptr_d = (cur_slot_q == SW'(NSLOT - 1)) ? '0 : cur_slot_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Pending bits and overflow. A new transition on a slot that is being
    // acknowledged in the same cycle is kept as a fresh pending event, and it
    // is not counted as an overflow. Set wins over ovf_clr.
    // -----------------------------------------------------------------------
    always_comb begin
        slot_clr = '0;
        if (ack) begin
            slot_clr[cur_slot_q] = 1'b1;
        end
        pend_d  = (pend_q & ~slot_clr) | slot_set;
        ovf_set = |(slot_set & pend_q & ~slot_clr);
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            presc_q     <= '0;
            btn_state_q <= '0;
            pend_q      <= '0;
            ovf_q       <= 1'b0;
            state_q     <= IDLE;
            cur_slot_q  <= '0;
            rr_ptr_q    <= '0;
            // NOTE: the counter array is a small bank of flops, not a RAM.
            // Resetting it element by element is intended, because the
            // debounce depends on every counter starting at zero.
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= btn_in;
            sync2_q     <= sync1_q;
            presc_q     <= presc_d;
            btn_state_q <= btn_state_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            cur_slot_q  <= cur_slot_d;
            rr_ptr_q    <= rr_ptr_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign btn_state = btn_state_q;
    assign evt_valid = (state_q == PRESENT);
    assign ovf       = ovf_q;
`ifdef BTN_RELEASE_EVT_EN
    assign evt_id      = cur_slot_q[SW-1:1];
    assign evt_release = cur_slot_q[0];
`else
    assign evt_id = cur_slot_q;
`endif

endmodule
